// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares a single ALU between two requesters with valid/ready handshakes.
// Each cycle the arbiter may grant one requester, drives the ALU with that
// requester's opcode and operands, and captures the ALU result and zero flag
// into a one-entry response buffer that is returned to the granted requester
// (the owner). The buffer can be drained and refilled in the same cycle, so
// an owner that keeps its response ready high sees one operation per cycle.
//
// Build option:
//   ALU_ARB_ROUND_ROBIN_EN  defined   -> ties alternate between requesters,
//                                        starting with req0 after reset.
//                           undefined -> fixed priority, req0 wins every tie
//                                        (req1 can starve under continuous
//                                        req0 traffic; this is intended).
//
// Ports:
//   iCLK, iRST                     clock (rising edge), synchronous active-high reset
//   iReqXValid / oReqXReady        request handshake (ready = granted this cycle)
//   iReqXControl, iReqXA, iReqXB   opcode and operands of requester X
//   oRspXValid / iRspXReady        response handshake, only the owner sees valid
//   oRspResult, oRspZero           registered ALU result / zero flag (shared bus)
//   oAluControl, oAluA, oAluB      to the ALU inputs (zero when nothing granted)
//   iAluResult, iAluZero           from the ALU outputs

module alu_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 5
) (
  input  logic              iCLK,
  input  logic              iRST,
  // requester 0
  input  logic              iReq0Valid,
  output logic              oReq0Ready,
  input  logic [CTRL_W-1:0] iReq0Control,
  input  logic [DATA_W-1:0] iReq0A,
  input  logic [DATA_W-1:0] iReq0B,
  // requester 1
  input  logic              iReq1Valid,
  output logic              oReq1Ready,
  input  logic [CTRL_W-1:0] iReq1Control,
  input  logic [DATA_W-1:0] iReq1A,
  input  logic [DATA_W-1:0] iReq1B,
  // responses
  output logic              oRsp0Valid,
  input  logic              iRsp0Ready,
  output logic              oRsp1Valid,
  input  logic              iRsp1Ready,
  output logic [DATA_W-1:0] oRspResult,
  output logic              oRspZero,
  // ALU side
  output logic [CTRL_W-1:0] oAluControl,
  output logic [DATA_W-1:0] oAluA,
  output logic [DATA_W-1:0] oAluB,
  input  logic [DATA_W-1:0] iAluResult,
  input  logic              iAluZero
);

  typedef enum logic [0:0] {
    StIdle, // response buffer empty
    StResp  // response buffer holds a result for owner_q
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;

  logic                owner_accept;
  logic                can_grant;
  logic                tie_pick1;
  logic                grant0;
  logic                grant1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Index of the most recent grant; reset to 1 so req0 wins the first tie.
  logic                last_q, last_d;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------

  // Only the owner's response ready matters; the other requester's is ignored.
  assign owner_accept = (state_q == StResp) && (owner_q ? iRsp1Ready : iRsp0Ready);

  // The buffer is free now, or is being drained this very cycle.
  assign can_grant = !iRST && ((state_q == StIdle) || owner_accept);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  assign tie_pick1 = (last_q == 1'b0);
`else
  assign tie_pick1 = 1'b0;
`endif

  // A single valid requester is always served; on a tie tie_pick1 decides.
  assign grant0 = can_grant && iReq0Valid && !(iReq1Valid && tie_pick1);
  assign grant1 = can_grant && iReq1Valid && !(iReq0Valid && !tie_pick1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q   <= last_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif

    if (grant0 || grant1) begin
      // A grant refills the buffer, replacing any response accepted this cycle.
      state_d  = StResp;
      owner_d  = grant1;
      result_d = iAluResult;
      zero_d   = iAluZero;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_d   = grant1;
`endif
    end else if (owner_accept) begin
      // Drained with nothing new: result/zero keep their last value.
      state_d = StIdle;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  always_comb begin
    oReq0Ready  = grant0;
    oReq1Ready  = grant1;
    oRsp0Valid  = (state_q == StResp) && !owner_q;
    oRsp1Valid  = (state_q == StResp) && owner_q;
    oAluControl = '0;
    oAluA       = '0;
    oAluB       = '0;
    if (grant0) begin
      oAluControl = iReq0Control;
      oAluA       = iReq0A;
      oAluB       = iReq0B;
    end else if (grant1) begin
      oAluControl = iReq1Control;
      oAluA       = iReq1A;
      oAluB       = iReq1B;
    end
  end

  assign oRspResult = result_q;
  assign oRspZero   = zero_q;

`ifndef SYNTHESIS
  // Internal consistency checks.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      a_one_grant : assert (!(grant0 && grant1))
        else $error("alu_arbiter: both requesters granted");
      a_grant_free : assert (!(grant0 || grant1) || can_grant)
        else $error("alu_arbiter: grant while buffer busy");
      a_grant_valid : assert ((!grant0 || iReq0Valid) && (!grant1 || iReq1Valid))
        else $error("alu_arbiter: grant without request");
    end
  end
`endif

endmodule
